// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin arbiter sharing one fixed-latency 64-bit adder among 4 requesters
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   per-requester handshake (4 bits, one-hot ready)
//   req_a/req_b           packed operands, requester i on bits [64i+63:64i]
//   add_a/add_b/add_cin   operands driven to the shared adder (cin tied 0)
//   add_sum/add_cout      adder result, valid LAT cycles after operands are driven
//   rsp_valid/rsp_ready   result handshake; rsp_id/rsp_sum/rsp_carry hold while valid
//   op_count              completed-operation counter (saturating), present only
//                         when the macro ADDER_ARB_STATS_EN is defined
module adder_rr_arbiter #(
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req_valid,
    output logic [3:0]   req_ready,
    input  logic [255:0] req_a,
    input  logic [255:0] req_b,
    output logic [63:0]  add_a,
    output logic [63:0]  add_b,
    output logic         add_cin,
    input  logic [63:0]  add_sum,
    input  logic         add_cout,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [1:0]   rsp_id,
    output logic [63:0]  rsp_sum,
    output logic         rsp_carry
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]  op_count
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    logic [1:0]  state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  id_q, id_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [63:0] a_q, a_d;
    logic [63:0] b_q, b_d;
    logic [63:0] sum_q, sum_d;
    logic        carry_q, carry_d;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    // Scan downward in offset so the closest set bit at/after ptr wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr_q + 2'(k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = ptr_q + 2'(k);
            end
        end
    end
    assign req_ready = (state_q == S_IDLE && gnt_vld) ? 4'(1) << gnt_id : 4'd0;
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = 1'b0;
    assign rsp_valid = state_q == S_RESP;
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            S_IDLE: if (gnt_vld) begin
                state_d = S_WAIT;
                id_d    = gnt_id;
                cnt_d   = 3'(LAT);
                a_d     = req_a[{gnt_id, 6'd0} +: 64];
                b_d     = req_b[{gnt_id, 6'd0} +: 64];
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Last WAIT cycle: the adder output now reflects the held operands.
                if (cnt_q == 3'd1) begin
                    state_d = S_RESP;
                    sum_d   = add_sum;
                    carry_d = add_cout;
                end
            end
            S_RESP: if (rsp_ready) begin
                state_d = S_IDLE;
                ptr_d   = id_q + 2'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            id_q    <= 2'd0;
            cnt_q   <= 3'd0;
            a_q     <= 64'd0;
            b_q     <= 64'd0;
            sum_q   <= 64'd0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end
`ifdef ADDER_ARB_STATS_EN
    logic [15:0] op_count_q;
    always_ff @(posedge clk) begin
        if (!rst_n)
            op_count_q <= 16'd0;
        else if (state_q == S_RESP && rsp_ready && op_count_q != 16'hFFFF)
            op_count_q <= op_count_q + 16'd1;
    end
    assign op_count = op_count_q;
`endif
endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: scoreboard bench for adder_rr_arbiter with a fixed-latency adder model
module tb_adder_rr_arbiter;
    localparam int LAT = 2;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [255:0] req_a, req_b;
    logic [63:0]  add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic         rsp_valid, rsp_ready, rsp_carry;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_sum;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]  op_count;
`endif
    always #5 clk = ~clk;
    adder_rr_arbiter #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry)
`ifdef ADDER_ARB_STATS_EN
        , .op_count(op_count)
`endif
    );
    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [64:0] full;
        int          cyc;
    } exp_t;
    exp_t q[$];
    int   glog_id[$];
    int   glog_cyc[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   age = 0;
    int   ops = 0;
    int   ptr = 0;
    int   cur_id = 0;
    bit   busy = 0;
    bit   seen = 0;
    logic [3:0]  last_ready = 4'd0;
    logic [66:0] hold;
    int          last_id;
    logic [63:0] last_sum;
    logic        last_carry;
    logic [64:0] full;
    function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction
    // Shared adder: returns the true sum only once the operands have been held LAT cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        age <= (rst_n && req_ready != 4'd0) ? 0 : (age < 1000 ? age + 1 : age);
    end
    assign full = {1'b0, add_a} + {1'b0, add_b} + {64'd0, add_cin};
    assign {add_cout, add_sum} = (age >= LAT - 1) ? full : ~full;
    // Reference model: one op in flight, grant = first valid at/after pointer, pointer = id+1 on completion.
    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        int g;
        bit fnd;
        if (!rst_n) begin
            busy = 0;
            ptr = 0;
            ops = 0;
            q.delete();
            last_ready = 4'd0;
        end else begin
            exp_rdy = 4'd0;
            fnd = 0;
            g = 0;
            if (!busy)
                for (int k = 0; k < 4; k++)
                    if (!fnd && req_valid[(ptr + k) % 4]) begin
                        fnd = 1;
                        g = (ptr + k) % 4;
                    end
            if (fnd) exp_rdy[g] = 1'b1;
            chk("req_ready", {124'd0, req_ready}, {124'd0, exp_rdy});
            last_ready = req_ready;
            if (fnd) begin
                q.push_back('{g, req_a[g*64 +: 64], req_b[g*64 +: 64],
                              {1'b0, req_a[g*64 +: 64]} + {1'b0, req_b[g*64 +: 64]}, cyc});
                glog_id.push_back(g);
                glog_cyc.push_back(cyc);
                busy = 1;
                cur_id = g;
            end else if (busy && rsp_valid && rsp_ready) begin
                busy = 0;
                ptr = (cur_id + 1) % 4;
                ops++;
            end
        end
    end
    // Monitor: pops the scoreboard when a new response appears, checks operands and holding.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            seen = 0;
        end else begin
            if (q.size() > 0 && !rsp_valid && cyc > q[0].cyc) begin
                chk("add_a", {64'd0, add_a}, {64'd0, q[0].a});
                chk("add_b", {64'd0, add_b}, {64'd0, q[0].b});
                chk("add_cin", {127'd0, add_cin}, 128'd0);
            end
            if (rsp_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        chk("rsp_spurious", {127'd0, rsp_valid}, 128'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_id", {126'd0, rsp_id}, 128'(e.id));
                        chk("rsp_sum", {64'd0, rsp_sum}, {64'd0, e.full[63:0]});
                        chk("rsp_carry", {127'd0, rsp_carry}, {127'd0, e.full[64]});
                        chk("rsp_latency", 128'(cyc - e.cyc), 128'(LAT + 1));
                    end
                    hold = {rsp_id, rsp_carry, rsp_sum};
                    last_id = int'(rsp_id);
                    last_sum = rsp_sum;
                    last_carry = rsp_carry;
                    seen = 1;
                end else begin
                    chk("rsp_hold", {61'd0, rsp_id, rsp_carry, rsp_sum}, {61'd0, hold});
                end
                if (rsp_ready) seen = 0;
            end
        end
    end
    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'd1;
            2: return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction
    task automatic issue(int i, logic [63:0] a, logic [63:0] b);
        int n = 0;
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
        req_valid[i] = 1'b1;
        do begin
            step();
            n++;
        end while (!last_ready[i] && n < 50);
        chk("grant_wait", {127'd0, last_ready[i]}, 128'd1);
        req_valid[i] = 1'b0;
    endtask
    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk("idle_wait", {127'd0, busy}, 128'd0);
    endtask
    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_wait", {127'd0, rsp_valid}, 128'd1);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [66:0] snap;
        int n;
        rst_n = 1'b0;
        req_valid = 4'd0;
        rsp_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        step(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        issue(0, 64'd5, 64'd7);
        wait_idle();
        chk("single_id", 128'(last_id), 128'd0);
        chk("single_sum", {64'd0, last_sum}, 128'd12);
        chk("single_carry", {127'd0, last_carry}, 128'd0);
        issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        wait_idle();
        chk("ovf_id", 128'(last_id), 128'd2);
        chk("ovf_sum", {64'd0, last_sum}, 128'd0);
        chk("ovf_carry", {127'd0, last_carry}, 128'd1);
        issue(3, 64'd100, 64'd200);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("wait_reset_norsp", {127'd0, rsp_valid}, 128'd0);
            step();
        end
        glog_id.delete();
        glog_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            req_a[i*64 +: 64] = rand64();
            req_b[i*64 +: 64] = rand64();
        end
        req_valid = 4'hF;
        n = 0;
        while (glog_id.size() < 5 && n < 100) begin
            step();
            n++;
            for (int i = 0; i < 4; i++)
                if (last_ready[i]) begin
                    req_a[i*64 +: 64] = rand64();
                    req_b[i*64 +: 64] = rand64();
                end
        end
        req_valid = 4'd0;
        chk("fair_count", 128'(glog_id.size()), 128'd5);
        for (int k = 0; k < 5 && k < glog_id.size(); k++) begin
            chk("fair_order", 128'(glog_id[k]), 128'(k % 4));
            if (k > 0) chk("fair_period", 128'(glog_cyc[k] - glog_cyc[k-1]), 128'(LAT + 2));
        end
        wait_idle();
        rsp_ready = 1'b0;
        issue(1, rand64(), rand64());
        req_a[0 +: 64] = rand64();
        req_b[0 +: 64] = rand64();
        req_a[128 +: 64] = rand64();
        req_b[128 +: 64] = rand64();
        req_valid = 4'b0101;
        wait_rsp();
        snap = {rsp_id, rsp_carry, rsp_sum};
        for (int k = 0; k < 10; k++) begin
            step();
            chk("bp_valid", {127'd0, rsp_valid}, 128'd1);
            chk("bp_stable", {61'd0, rsp_id, rsp_carry, rsp_sum}, {61'd0, snap});
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_exit", {127'd0, rsp_valid}, 128'd0);
        n = 0;
        while ((req_valid != 4'd0 || busy) && n < 100) begin
            step();
            n++;
            for (int i = 0; i < 4; i++)
                if (last_ready[i]) req_valid[i] = 1'b0;
        end
        chk("bp_drain", {124'd0, req_valid}, 128'd0);
        wait_idle();
        rsp_ready = 1'b0;
        issue(3, rand64() | 64'd1, 64'd2);
        wait_rsp();
        rst_n = 1'b0;
        step();
        chk("rst_rsp_valid", {127'd0, rsp_valid}, 128'd0);
        chk("rst_rsp_id", {126'd0, rsp_id}, 128'd0);
        chk("rst_rsp_sum", {64'd0, rsp_sum}, 128'd0);
        chk("rst_rsp_carry", {127'd0, rsp_carry}, 128'd0);
        chk("rst_add_a", {64'd0, add_a}, 128'd0);
        chk("rst_add_b", {64'd0, add_b}, 128'd0);
        chk("rst_req_ready", {124'd0, req_ready}, 128'd0);
`ifdef ADDER_ARB_STATS_EN
        chk("rst_op_count", {112'd0, op_count}, 128'd0);
`endif
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step();
        for (int k = 0; k < 2000; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (last_ready[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_a[i*64 +: 64] = rand64();
                    req_b[i*64 +: 64] = rand64();
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_a[i*64 +: 64] = rand64();
                        req_b[i*64 +: 64] = rand64();
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = $urandom_range(0, 9) < 7;
            step();
        end
        req_valid = 4'd0;
        rsp_ready = 1'b1;
        wait_idle();
        step(2);
        chk("final_queue_empty", 128'(q.size()), 128'd0);
`ifdef ADDER_ARB_STATS_EN
        chk("op_count", {112'd0, op_count}, ops > 65535 ? 128'hFFFF : 128'(ops));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
